// File: rtl/rstack_pkg.sv
// Shared definitions for the return-address stack: op encodings, response FSM
// states and the default PC width.
package rstack_pkg;

  localparam int RS_DATA_W = 19;

  localparam logic [1:0] RS_PUSH  = 2'b00;
  localparam logic [1:0] RS_POP   = 2'b01;
  localparam logic [1:0] RS_PEEK  = 2'b10;
  localparam logic [1:0] RS_FLUSH = 2'b11;

  typedef enum logic {
    RS_IDLE = 1'b0,
    RS_RESP = 1'b1
  } rs_state_e;

endpackage

// File: rtl/rstack_mem.sv
// Return-stack storage: DEPTH x DATA_W register file, one synchronous write
// port and one combinational read port. Contents are never reset.
module rstack_mem #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack with a valid/ready request and response channel.
// Optional feature macro RSTACK_ERR_STICKY_EN adds the err_sticky/err_clr ports.
module return_stack
  import rstack_pkg::*;
#(
  parameter int DATA_W = RS_DATA_W,
  parameter int DEPTH  = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [DATA_W-1:0]      req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
`ifdef RSTACK_ERR_STICKY_EN
  output logic                   err_sticky,
  input  logic                   err_clr,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  rs_state_e         state_q;
  logic [PW-1:0]     wp_q, wp_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] top_s;
  logic              accept_s, full_s, empty_s, we_s;

  assign full_s    = (count_q == CW'(DEPTH));
  assign empty_s   = (count_q == CW'(0));
  assign rsp_valid = (state_q == RS_RESP);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept_s  = req_valid && req_ready;
  assign we_s      = accept_s && (req_op == RS_PUSH) && !full_s;

  rstack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (we_s),
    .waddr_i (wp_q),
    .wdata_i (req_data),
    .raddr_i (wp_q - PW'(1)),
    .rdata_o (top_s)
  );

  // next pointer, count and response for the op on the request channel
  always_comb begin
    wp_d       = wp_q;
    count_d    = count_q;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    case (req_op)
      RS_PUSH: begin
        if (full_s) begin
          rsp_err_d = 1'b1;
        end else begin
          wp_d    = wp_q + PW'(1);
          count_d = count_q + CW'(1);
        end
      end
      RS_POP: begin
        if (empty_s) begin
          rsp_err_d = 1'b1;
        end else begin
          rsp_data_d = top_s;
          wp_d       = wp_q - PW'(1);
          count_d    = count_q - CW'(1);
        end
      end
      RS_PEEK: begin
        if (empty_s) begin
          rsp_err_d = 1'b1;
        end else begin
          rsp_data_d = top_s;
        end
      end
      RS_FLUSH: begin
        wp_d    = '0;
        count_d = '0;
      end
      default: begin
        rsp_err_d = 1'b0;
      end
    endcase
  end

  // response FSM with stack state and registered response payload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RS_IDLE;
      wp_q       <= '0;
      count_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        RS_IDLE: begin
          if (accept_s) state_q <= RS_RESP;
        end
        RS_RESP: begin
          if (accept_s)       state_q <= RS_RESP;
          else if (rsp_ready) state_q <= RS_IDLE;
        end
        default: state_q <= RS_IDLE;
      endcase
      if (accept_s) begin
        wp_q       <= wp_d;
        count_q    <= count_d;
        rsp_data_q <= rsp_data_d;
        rsp_err_q  <= rsp_err_d;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign count    = count_q;
  assign full     = full_s;
  assign empty    = empty_s;

`ifdef RSTACK_ERR_STICKY_EN
  logic err_sticky_q;

  // a new error response beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else if (accept_s && rsp_err_d) begin
      err_sticky_q <= 1'b1;
    end else if (err_clr) begin
      err_sticky_q <= 1'b0;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: a queue-based LIFO model predicts each
// response, a negedge monitor checks every handshaken response.
module tb_return_stack;
  import rstack_pkg::*;

  localparam int DW    = 19;
  localparam int DEPTH = 256;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = 2'b00;
  logic [DW-1:0] req_data = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready, rsp_valid, rsp_err, full, empty;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] count;
`ifdef RSTACK_ERR_STICKY_EN
  logic          err_clr = 1'b0;
  logic          err_sticky;
`endif

  return_stack #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
`ifdef RSTACK_ERR_STICKY_EN
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
`endif
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned stk[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // response monitor: every handshaken response must match the oldest prediction
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", int'(rsp_data), int'(e.d));
        chk("rsp_err", int'(rsp_err), int'(e.e));
      end
    end
  end

  // issue one request; returns just after the accepting edge with req_valid still high
  task automatic do_req(input logic [1:0] op, input logic [DW-1:0] d, input bit rnd_rdy,
                        output int waits);
    bit   got;
    exp_t e;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    waits     = 0;
    got       = 1'b0;
    while (!got && waits < 200) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
      end else begin
        waits++;
        @(posedge clk); #1;
        if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
    if (!got) begin
      chk("req_accept_timeout", waits, 0);
      req_valid = 1'b0;
      return;
    end
    e = '0;
    case (op)
      RS_PUSH:  if (stk.size() == DEPTH) e.e = 1'b1; else stk.push_back(int'(d));
      RS_POP:   if (stk.size() == 0) e.e = 1'b1; else e.d = DW'(stk.pop_back());
      RS_PEEK:  if (stk.size() == 0) e.e = 1'b1; else e.d = DW'(stk[$]);
      default:  stk.delete();
    endcase
    exp_q.push_back(e);
    @(posedge clk); #1;
    chk("count", int'(count), stk.size());
    chk("full", int'(full), int'(stk.size() == DEPTH));
    chk("empty", int'(empty), int'(stk.size() == 0));
    if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int unsigned top;
    int          r;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_req_ready", int'(req_ready), 1);
`ifdef RSTACK_ERR_STICKY_EN
    chk("rst_err_sticky", int'(err_sticky), 0);
`endif

    // basic LIFO order, back to back
    do_req(RS_PUSH, 19'h00010, 1'b0, w);
    do_req(RS_PUSH, 19'h00020, 1'b0, w);
    do_req(RS_PUSH, 19'h00030, 1'b0, w);
    do_req(RS_POP, 19'h0, 1'b0, w);
    do_req(RS_POP, 19'h0, 1'b0, w);
    do_req(RS_POP, 19'h0, 1'b0, w);

    // underflow
    do_req(RS_POP, 19'h0, 1'b0, w);
`ifdef RSTACK_ERR_STICKY_EN
    chk("sticky_set", int'(err_sticky), 1);
    do_req(RS_PUSH, 19'h00005, 1'b0, w);
    do_req(RS_POP, 19'h0, 1'b0, w);
    chk("sticky_held", int'(err_sticky), 1);
    req_valid = 1'b0;
    err_clr   = 1'b1;
    @(posedge clk); #1;
    err_clr   = 1'b0;
    chk("sticky_clr", int'(err_sticky), 0);
`endif

    // fill to full, overflow, peek
    for (int v = 0; v < DEPTH; v++) do_req(RS_PUSH, DW'(v), 1'b0, w);
    do_req(RS_PUSH, 19'h7FFFF, 1'b0, w);
    do_req(RS_PEEK, 19'h0, 1'b0, w);

    // consumer stall holds the response and blocks new requests
    top = stk[$];
    do_req(RS_POP, 19'h0, 1'b0, w);
    rsp_ready = 1'b0;
    req_op    = RS_PUSH;
    req_data  = 19'h00123;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", int'(rsp_valid), 1);
      chk("stall_rsp_data", int'(rsp_data), int'(top));
      chk("stall_req_ready", int'(req_ready), 0);
      @(posedge clk); #1;
    end
    chk("stall_count", int'(count), stk.size());
    rsp_ready = 1'b1;
    do_req(RS_PUSH, 19'h00123, 1'b0, w);
    chk("accept_on_ready", w, 0);

    // flush
    do_req(RS_FLUSH, 19'h0, 1'b0, w);
    do_req(RS_PUSH, 19'h00032, 1'b0, w);
    do_req(RS_FLUSH, 19'h0, 1'b0, w);
    do_req(RS_POP, 19'h0, 1'b0, w);

    // reset while a response is pending
    do_req(RS_PUSH, 19'h00055, 1'b0, w);
    rsp_ready = 1'b0;
    req_op    = RS_PUSH;
    req_data  = 19'h00066;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    stk.delete();
    exp_q.delete();
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    do_req(RS_PEEK, 19'h0, 1'b0, w);

    // randomized traffic with a randomly stalling consumer
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 19);
      if (r < 9)       do_req(RS_PUSH, DW'($urandom), 1'b1, w);
      else if (r < 15) do_req(RS_POP, DW'($urandom), 1'b1, w);
      else if (r < 19) do_req(RS_PEEK, DW'($urandom), 1'b1, w);
      else             do_req(RS_FLUSH, DW'($urandom), 1'b1, w);
    end

    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
